// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: byte-serial command port driving one valid/ready memory-bus beat per command, with timeout.
module uart_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_overrun
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, last_q, last_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d, tmo_q, tmo_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    resp_d = resp_q;
    tmo_d = tmo_q;
    err_d = err_q | (rx_valid && (state_q == BUS || state_q == RESP));
    case (state_q)
      IDLE: if (rx_valid) begin
        cnt_d = 2'd0;
        last_d = 2'd0;
        if (rx_data == 8'h01 || rx_data == 8'h02) begin
          wr_d = rx_data == 8'h01;
          state_d = ADDR;
        end else begin
          resp_d = 32'h0000_00EE;
          state_d = RESP;
        end
      end
      ADDR: if (rx_valid) begin
        addr_d[8*cnt_q +: 8] = rx_data;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = wr_q ? DATA : BUS;
          tmo_d = 32'd0;
        end
      end
      DATA: if (rx_valid) begin
        wdata_d[8*cnt_q +: 8] = rx_data;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = BUS;
          tmo_d = 32'd0;
        end
      end
      BUS: begin
        tmo_d = tmo_q + 32'd1;
        // a completion on the timeout edge still counts as a completion
        if (mem_ready) begin
          state_d = RESP;
          cnt_d = 2'd0;
          resp_d = wr_q ? 32'h0000_00A5 : mem_rdata;
          last_d = wr_q ? 2'd0 : 2'd3;
        end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          state_d = RESP;
          cnt_d = 2'd0;
          resp_d = 32'h0000_00EE;
          last_d = 2'd0;
        end
      end
      RESP: if (tx_ready) begin
        cnt_d = cnt_q == last_q ? 2'd0 : cnt_q + 2'd1;
        state_d = cnt_q == last_q ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      last_q <= 2'd0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      resp_q <= 32'd0;
      tmo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      wr_q <= wr_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_q <= resp_d;
      tmo_q <= tmo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign mem_valid = state_q == BUS;
  assign tx_valid = state_q == RESP;
  assign tx_data = tx_valid ? resp_q[8*cnt_q +: 8] : 8'h00;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = {4{wr_q}};
  assign err_overrun = err_q;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: randomized commands against a command-level reference model with a decoupled scoreboard.
module tb_uart_bus_bridge;
  localparam int T = 16;
  logic clk = 0, resetn = 0, rx_valid = 0, tx_ready = 0, mem_ready = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] mem_rdata = 0;
  logic tx_valid, mem_valid, busy, err_overrun;
  logic [7:0] tx_data;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;

  uart_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk_wd;
    int          dur;
  } beat_t;

  beat_t exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_cmp = 0, n_bad = 0;
  int rsp_lat = 0, tx_stall = 0;
  bit exp_err = 0, bus_act = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Responder + bus monitor: one process so mem_ready is decided after observing mem_valid.
  initial begin : bus_mon
    beat_t cur;
    bit have;
    int dur;
    have = 0;
    dur = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus_act = 0;
        mem_ready = 0;
      end else if (mem_valid) begin
        if (!bus_act) begin
          bus_act = 1;
          dur = 0;
          have = exp_bus.size() > 0;
          if (have) cur = exp_bus.pop_front();
          else begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_unexpected: got beat at %0h want none", mem_addr);
          end
        end
        if (have) begin
          chk("mem_addr", mem_addr, cur.addr);
          if (cur.chk_wd) chk("mem_wdata", mem_wdata, cur.wdata);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
        end
        mem_ready = rsp_lat >= 0 && dur == rsp_lat;
        dur++;
      end else begin
        if (bus_act && have) chk("bus_cycles", 32'(dur), 32'(cur.dur));
        bus_act = 0;
        mem_ready = $urandom_range(0, 3) == 0;
      end
    end
  end

  // Transmit sink + response checker.
  initial begin : tx_mon
    int sc;
    sc = 0;
    forever begin
      @(negedge clk);
      if (resetn && tx_valid) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got %0h want none", tx_data);
          tx_ready = 1;
        end else begin
          chk("tx_data", 32'(tx_data), 32'(exp_tx[0]));
          tx_ready = sc >= tx_stall;
          sc = tx_ready ? 0 : sc + 1;
          if (tx_ready) void'(exp_tx.pop_front());
        end
      end else begin
        sc = 0;
        tx_ready = $urandom_range(0, 1) == 1;
      end
    end
  end

  task automatic send(input logic [7:0] b[$], input bit inj);
    @(negedge clk);
    for (int i = 0; i < b.size(); i++) begin
      rx_valid = 1;
      rx_data = b[i];
      @(negedge clk);
      rx_valid = 0;
      if (i != b.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (inj) begin
      rx_valid = 1;
      rx_data = 8'($urandom);
      exp_err = 1;
      @(negedge clk);
      rx_valid = 0;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp_tx.size() != 0 || busy || bus_act) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_timeout: got busy=%0d pending=%0d want idle", busy, exp_tx.size());
    end
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    chk("err_overrun", 32'(err_overrun), 32'(exp_err));
    chk("bus_beats_left", 32'(exp_bus.size()), 0);
    exp_bus.delete();
    exp_tx.delete();
  endtask

  // Reference model: a command's bus beat and response bytes follow directly from opcode and responder latency.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input int stall, input bit inj);
    logic [7:0] b[$];
    beat_t e;
    bit ok;
    rsp_lat = lat;
    tx_stall = stall;
    mem_rdata = rdata;
    b.push_back(op);
    if (op == 8'h01 || op == 8'h02) begin
      for (int i = 0; i < 4; i++) b.push_back(addr[8*i +: 8]);
      if (op == 8'h01) for (int i = 0; i < 4; i++) b.push_back(wdata[8*i +: 8]);
      ok = lat >= 0 && lat < T;
      e.addr = addr;
      e.wdata = wdata;
      e.wstrb = op == 8'h01 ? 4'hF : 4'h0;
      e.chk_wd = op == 8'h01;
      e.dur = ok ? lat + 1 : T;
      exp_bus.push_back(e);
      if (!ok) exp_tx.push_back(8'hEE);
      else if (op == 8'h01) exp_tx.push_back(8'hA5);
      else for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
    end else exp_tx.push_back(8'hEE);
    send(b, inj && b.size() > 1);
    wait_idle();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] q[$];
    beat_t e;
    logic [7:0] op;
    int r;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_overrun), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    resetn = 1;
    run_cmd(8'h01, 32'h2000_0000, 32'hDEAD_BEEF, 32'h0, 3, 0, 0);
    run_cmd(8'h02, 32'h2010_0028, 32'h0, 32'h1234_5678, 2, 1, 0);
    run_cmd(8'h02, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, -1, 0, 0);
    run_cmd(8'h02, 32'h0000_0004, 32'h0, 32'hA1B2_C3D4, T - 1, 0, 0);
    run_cmd(8'h01, 32'h0000_0008, 32'h5555_AAAA, 32'h0, T, 0, 0);
    run_cmd(8'h7F, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_cmd(8'h02, 32'h8000_0010, 32'h0, 32'h89AB_CDEF, 1, 5, 0);
    run_cmd(8'h01, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 0, 0, 1);
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 4);
      op = r < 2 ? 8'h01 : r < 4 ? 8'h02 : 8'($urandom);
      run_cmd(op, $urandom, $urandom, $urandom,
              $urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(0, T)),
              $urandom_range(0, 2), $urandom_range(0, 5) == 0);
    end
    // Reset in the middle of a bus beat, with a byte offered while reset is held.
    rsp_lat = -1;
    tx_stall = 0;
    e.addr = 32'h3000_0100;
    e.wdata = 32'h0;
    e.wstrb = 4'h0;
    e.chk_wd = 0;
    e.dur = T;
    exp_bus.push_back(e);
    q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h30};
    send(q, 1);
    chk("midbus_valid", 32'(mem_valid), 1);
    chk("midbus_err", 32'(err_overrun), 1);
    resetn = 0;
    rx_valid = 1;
    rx_data = 8'h01;
    @(negedge clk);
    chk("abort_mem_valid", 32'(mem_valid), 0);
    chk("abort_err", 32'(err_overrun), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_tx_valid", 32'(tx_valid), 0);
    chk("abort_mem_addr", mem_addr, 0);
    rx_valid = 0;
    resetn = 1;
    exp_err = 0;
    exp_bus.delete();
    exp_tx.delete();
    run_cmd(8'h02, 32'h0000_0200, 32'h0, 32'hFEED_0123, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: bus cycles allowed between mem_valid rise and mem_ready before the transaction is aborted.
REQ-002 clk  in  1  system clock.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 rx_valid  in  1  single-cycle strobe; a received byte is present on rx_data.
REQ-005 rx_data  in  8  received byte.
REQ-006 tx_valid  out  1  a response byte is present on tx_data.
REQ-007 tx_data  out  8  response byte.
REQ-008 tx_ready  in  1  the transmitter accepts tx_data on a clk edge where tx_valid=1 and tx_ready=1.
REQ-009 mem_valid  out  1  bus request, initiator side of the SoC valid/ready memory bus.
REQ-010 mem_addr  out  32  byte address.
REQ-011 mem_wdata  out  32  write data.
REQ-012 mem_wstrb  out  4  write strobes: 4'hF for a write, 4'h0 for a read.
REQ-013 mem_ready  in  1  one-cycle completion from the responder.
REQ-014 mem_rdata  in  32  read data, valid in the mem_ready cycle.
REQ-015 busy  out  1  high in every state other than IDLE.
REQ-016 err_overrun  out  1  sticky flag: a byte was dropped.

Function
REQ-017 The FSM SHALL have the states IDLE, ADDR, DATA, BUS, RESP.
REQ-018 In IDLE, rx byte 0x01 (WRITE) or 0x02 (READ) SHALL latch the opcode and go to ADDR.
REQ-019 In IDLE, any other rx byte SHALL load the response 0xEE (length 1) and go to RESP.
REQ-020 ADDR SHALL collect 4 bytes little-endian into mem_addr (first byte goes to [7:0]).
REQ-021 After the 4th ADDR byte, ADDR SHALL go to DATA for WRITE and to BUS for READ.
REQ-022 DATA SHALL collect 4 bytes little-endian into mem_wdata, then go to BUS.
REQ-023 mem_valid SHALL rise on the clk edge that enters BUS, i.e. it is visible in the cycle after the last command byte.
REQ-024 mem_addr, mem_wdata and mem_wstrb SHALL be stable while mem_valid=1.
REQ-025 On an edge with mem_valid=1 and mem_ready=1, the block SHALL deassert mem_valid (low in the next cycle) and capture mem_rdata.
REQ-026 On that completion edge the block SHALL go to RESP: WRITE loads the response 0xA5 (length 1); READ loads the 4 rdata bytes little-endian (length 4).
REQ-027 A 16-bit-or-wider timeout counter SHALL clear on BUS entry and increment each cycle in BUS.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 without mem_ready, the block SHALL drop mem_valid and go to RESP with the response 0xEE (length 1).
REQ-029 If mem_ready and the timeout occur on the same edge, mem_ready SHALL win.
REQ-030 mem_ready while mem_valid=0 SHALL be ignored.
REQ-031 In RESP, tx_valid=1 and tx_data SHALL carry the current response byte.
REQ-032 Each tx handshake SHALL advance to the next byte, which is presented in the following cycle.
REQ-033 The handshake on the last response byte SHALL return the FSM to IDLE with tx_valid=0 in the next cycle.
REQ-034 tx_data SHALL hold its value while tx_valid=1 and tx_ready=0.
REQ-035 An rx_valid byte arriving in BUS or RESP SHALL be discarded and SHALL set err_overrun.
REQ-036 A byte counter (2 bits) SHALL index both collection and response; it resets on every state entry.

Reset
REQ-037 While resetn=0 at a clk edge, the next state SHALL be IDLE, with mem_valid=0, tx_valid=0, busy=0, err_overrun=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, tx_data=0, and the counters at 0.
REQ-038 Reset asserted in any state, including mid-bus with mem_valid=1, SHALL abort immediately without completing the transfer.
REQ-039 rx_valid during reset SHALL be ignored.

Verification
REQ-040 Rx 01 00 00 00 20 EF BE AD DE, responder ready after 3 cycles -> one bus beat: addr 0x2000_0000, wdata 0xDEAD_BEEF, wstrb F; then tx 0xA5; busy returns to 0.
REQ-041 Rx 02 28 00 10 20, rdata 0x1234_5678 -> bus beat addr 0x2010_0028, wstrb 0; then tx 78 56 34 12.
REQ-042 Rx 02 + address with mem_ready never asserted -> mem_valid drops after exactly TIMEOUT_CYCLES cycles; then tx 0xEE.
REQ-043 Rx 0x7F in IDLE -> tx 0xEE and no bus activity.
REQ-044 Read response with tx_ready held low for 5 cycles per byte -> tx_data stable during each stall; the 4 bytes arrive in order.
REQ-045 Rx byte injected during BUS -> err_overrun=1, command result unchanged; reset mid-BUS -> mem_valid=0 on the next cycle and err_overrun cleared.
